// File: rtl/uart_tx_byte_feeder_pkg.sv
// Shared types and defaults for the UART byte feeder slice.
package uart_tx_byte_feeder_pkg;

    // Feeder FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } feeder_state_e;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_ACK_TIMEOUT = 8;

    // Width of a counter that must hold values 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO. Head data is read combinationally; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     uart_clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // full is judged on the current level, so a same-cycle pop never frees room
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    // Pointer advance; contents are discarded simply by resetting pointers
    always_ff @(posedge uart_clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write, no reset needed
    always_ff @(posedge uart_clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_byte_feeder.sv
// Drains a byte FIFO into the simulation UART transmitter's edge-triggered
// request/data/ack handshake, with ack timeout and overflow reporting.
module uart_tx_byte_feeder
    import uart_tx_byte_feeder_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                     uart_clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     request,
    output logic [7:0]               data,
    input  logic                     ack,
    output logic                     idle,
    output logic                     ovf,
    output logic                     tmo,
    input  logic                     clr_err
);
    localparam int CW = cnt_width(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    feeder_state_e state, state_nx;
    logic          request_nx;
    logic [7:0]    data_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pop;
    logic          tmo_set;
    logic          ovf_set;
    logic          launch_ok;
    logic [7:0]    head;
    logic          empty;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .uart_clk (uart_clk),
        .rstn     (rstn),
        .push     (wr_en),
        .wr_data  (wr_data),
        .pop      (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    assign launch_ok = !empty && !ack;
    assign ovf_set   = wr_en && full;
    assign idle      = empty && (state == ST_IDLE) && !ack;

    // Next-state and handshake outputs; a launch always comes from a cycle
    // with request low, so the transmitter sees a fresh rising edge per byte
    always_comb begin
        state_nx   = state;
        request_nx = request;
        data_nx    = data;
        cnt_nx     = cnt;
        pop        = 1'b0;
        tmo_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch_ok) begin
                    data_nx    = head;
                    pop        = 1'b1;
                    request_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    request_nx = 1'b0;
                    state_nx   = ST_BUSY;
                end else if (cnt == TMO_LAST) begin
                    request_nx = 1'b0;
                    tmo_set    = 1'b1;
                    state_nx   = ST_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                request_nx = 1'b0;
                if (!ack) begin
                    if (!empty) begin
                        data_nx    = head;
                        pop        = 1'b1;
                        request_nx = 1'b1;
                        cnt_nx     = '0;
                        state_nx   = ST_REQ;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                request_nx = 1'b0;
                state_nx   = ST_IDLE;
            end
        endcase
    end

    // FSM, handshake and timeout counter registers
    always_ff @(posedge uart_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            request <= 1'b0;
            data    <= 8'h00;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            request <= request_nx;
            data    <= data_nx;
            cnt     <= cnt_nx;
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge uart_clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
        end else begin
            ovf <= (ovf && !clr_err) || ovf_set;
            tmo <= (tmo && !clr_err) || tmo_set;
        end
    end

endmodule

// File: tb/tb_uart_tx_byte_feeder.sv
// Bench for uart_tx_byte_feeder: a behavioural transmitter model pops the
// expected-byte queue whenever it latches a byte off the request edge.
module tb_uart_tx_byte_feeder;
    logic       uart_clk = 1'b0;
    logic       rstn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [4:0] level;
    logic       request;
    logic [7:0] data;
    logic       ack;
    logic       idle;
    logic       ovf;
    logic       tmo;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // 0: transmitter model, 1: ack tied high, 2: ack tied low
    int   ack_sel = 2;
    logic model_ack;
    logic del_req = 1'b0;
    int   busy_cnt = 0;
    int   tx_cnt = 0;
    int   rise_cnt = 0;
    logic prev_req = 1'b0;

    always #5 uart_clk = ~uart_clk;

    assign model_ack = (busy_cnt != 0);
    assign ack = (ack_sel == 0) ? model_ack : (ack_sel == 1);

    uart_tx_byte_feeder #(.DEPTH(16), .ACK_TIMEOUT(8)) dut (
        .uart_clk (uart_clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .request  (request),
        .data     (data),
        .ack      (ack),
        .idle     (idle),
        .ovf      (ovf),
        .tmo      (tmo),
        .clr_err  (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: latch on request rising edge, busy for 10 cycles
    always @(posedge uart_clk) begin
        del_req <= request;
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (ack_sel == 0 && request && !del_req) begin
            busy_cnt <= 10;
            tx_cnt   <= tx_cnt + 1;
            check("tx_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_byte", data, exp_q.pop_front());
        end
    end

    // Count request rising edges for the no-launch checks
    always @(posedge uart_clk) begin
        prev_req <= request;
        if (request && !prev_req) rise_cnt <= rise_cnt + 1;
    end

    task automatic tick();
        @(posedge uart_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_tx) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (!idle && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, idle, 1);
    endtask

    initial begin
        int base;
        int n;
        int hi;
        int rises;
        rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        // reset state
        check("rst_request", request, 0);
        check("rst_data", data, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tmo", tmo, 0);
        check("rst_idle", idle, 1);

        // loopback of four bytes
        ack_sel = 0;
        base = tx_cnt;
        push(8'h55, 1); push(8'hA3, 1); push(8'h00, 1); push(8'hFF, 1);
        wait_idle(300, "lb_idle");
        check("lb_level", level, 0);
        check("lb_count", tx_cnt - base, 4);
        check("lb_queue", exp_q.size(), 0);

        // fill with ack stuck high, then overflow with clr_err same cycle
        ack_sel = 1;
        tick();
        rises = rise_cnt;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1);
        check("fill_level", level, 16);
        check("fill_full", full, 1);
        check("fill_ovf_clear", ovf, 0);
        clr_err = 1'b1;
        push(8'h99, 0);
        clr_err = 1'b0;
        check("ovf_set_wins", ovf, 1);
        check("ovf_level", level, 16);
        repeat (5) tick();
        check("ovf_sticky", ovf, 1);
        check("no_request", rise_cnt - rises, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_cleared", ovf, 0);

        // push and pop in the same cycle on a full FIFO
        ack_sel = 0;
        base = tx_cnt;
        push(8'hEE, 0);
        check("pp_level", level, 15);
        check("pp_ovf", ovf, 1);
        n = 0;
        while (level > 12 && n < 300) begin
            tick();
            n++;
        end
        check("pp_drain_progress", (level <= 12), 1);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1);
        wait_idle(600, "wrap_idle");
        check("wrap_count", tx_cnt - base, 20);
        check("wrap_queue", exp_q.size(), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // ack never arrives: timeout
        ack_sel = 2;
        push(8'h3C, 0);
        n = 0;
        while (!request && n < 10) begin
            tick();
            n++;
        end
        check("tmo_req_rise", request, 1);
        check("tmo_pre", tmo, 0);
        hi = 0;
        while (request && hi < 50) begin
            tick();
            hi++;
        end
        check("tmo_req_cycles", hi, 8);
        check("tmo_flag", tmo, 1);
        check("tmo_level", level, 0);
        check("tmo_idle", idle, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_cleared", tmo, 0);

        // reset in the middle of the second frame of a burst
        ack_sel = 0;
        base = tx_cnt;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1);
        n = 0;
        while (tx_cnt < base + 2 && n < 200) begin
            tick();
            n++;
        end
        check("burst_two_sent", tx_cnt - base, 2);
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_request", request, 0);
        check("mid_rst_level", level, 0);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        n = 0;
        while (ack && n < 30) begin
            tick();
            n++;
        end
        tick();
        check("post_rst_idle", idle, 1);
        check("post_rst_no_tx", tx_cnt - base, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
